// File: rtl/sdram_arbiter.sv
// sdram_arbiter: three-way arbiter in front of a single SDRAM port.
// It serves the ROM loader (byte writes), port A (P-ROM/S-ROM, read/write)
// and port B (C-ROM, read-only). One access is in flight at a time, using a
// request/acknowledge handshake on the memory side.
module sdram_arbiter #(
  parameter int ADDR_W = 25
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rom_loading,
  // ROM loader byte-write strobe
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [7:0]        ldr_data,
  input  logic              ldr_wr,
  output logic              ldr_busy,
  output logic              ldr_overrun,
  // Port A: P-ROM/S-ROM, read/write
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [15:0]       a_din,
  output logic [15:0]       a_dout,
  output logic              a_ack,
  // Port B: C-ROM, read-only
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [15:0]       b_dout,
  output logic              b_ack,
  // Memory side, 16-bit word addressed
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-2:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic [1:0]        mem_be,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  typedef enum logic [1:0] {OWN_A, OWN_B, OWN_LDR} owner_t;

  state_t            state;
  owner_t            owner;
  logic              last_b;       // 1: the last A/B grant went to B
  logic [ADDR_W-1:0] ldr_addr_q;
  logic [7:0]        ldr_data_q;

  logic gnt_ldr;
  logic gnt_b;
  logic gnt_a;

  // Grant selection for the IDLE cycle: a pending loader write always wins.
  // A and B take turns on a tie and are held off entirely while loading ROMs.
  assign gnt_ldr = ldr_busy;
  assign gnt_b   = !ldr_busy && !rom_loading && b_req && (!a_req || !last_b);
  assign gnt_a   = !ldr_busy && !rom_loading && a_req && !gnt_b;

  // Access FSM, registered memory-side outputs, port acks and loader latch.
  // NOTE: every register in this block uses non-blocking assignment so that all
  // of them update from the same pre-edge values; a blocking write here would
  // let later statements see the new value and break the handshake timing.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: the read-data holding registers are reset too; they are plain
    // flops, not a RAM, so resetting them is cheap and gives defined outputs.
    if (reset) begin
      state       <= IDLE;
      owner       <= OWN_A;
      last_b      <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_be      <= '0;
      a_ack       <= 1'b0;
      b_ack       <= 1'b0;
      a_dout      <= '0;
      b_dout      <= '0;
      ldr_busy    <= 1'b0;
      ldr_overrun <= 1'b0;
      ldr_addr_q  <= '0;
      ldr_data_q  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (gnt_ldr) begin
            owner     <= OWN_LDR;
            state     <= WAIT;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= ldr_addr_q[ADDR_W-1:1];
            mem_wdata <= {ldr_data_q, ldr_data_q};
            // Big-endian words: even byte address is the high byte lane.
            mem_be    <= ldr_addr_q[0] ? 2'b01 : 2'b10;
          end else if (gnt_b) begin
            owner     <= OWN_B;
            last_b    <= 1'b1;
            state     <= WAIT;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= b_addr[ADDR_W-1:1];
            mem_wdata <= '0;
            mem_be    <= 2'b11;
          end else if (gnt_a) begin
            owner     <= OWN_A;
            last_b    <= 1'b0;
            state     <= WAIT;
            mem_req   <= 1'b1;
            mem_we    <= a_we;
            mem_addr  <= a_addr[ADDR_W-1:1];
            mem_wdata <= a_din;
            mem_be    <= 2'b11;
          end
        end
        WAIT: begin
          // Hold the request and its companions steady until acknowledged.
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= DONE;
            unique case (owner)
              OWN_A: begin
                a_ack  <= 1'b1;
                a_dout <= mem_rdata;
              end
              OWN_B: begin
                b_ack  <= 1'b1;
                b_dout <= mem_rdata;
              end
              default: ldr_busy <= 1'b0;
            endcase
          end
        end
        default: begin
          // DONE: acks last exactly one cycle; requests seen here are ignored.
          a_ack <= 1'b0;
          b_ack <= 1'b0;
          state <= IDLE;
        end
      endcase

      // Loader strobe: accepted only when no write is pending, else sticky
      // overrun. Busy is only set while clear and only cleared while set, so
      // this never fights the clear above.
      if (ldr_wr) begin
        if (!ldr_busy) begin
          ldr_addr_q <= ldr_addr;
          ldr_data_q <= ldr_data;
          ldr_busy   <= 1'b1;
        end else begin
          ldr_overrun <= 1'b1;
        end
      end
    end
  end

endmodule
